inst_fetch_unit: RTL and testbench

Responder side of the instruction-fetch port (`mc_en`/`mc_addr`/`mc_rdy`/`mc_data`) driven by the decoder. It accepts a word-aligned fetch request, reads the 32-bit instruction as four little-endian bytes from the byte-wide unified RAM through the memory arbiter, and returns it with a one-cycle `mc_rdy` pulse. It sits between the decoder and the memory arbiter. A direct-mapped instruction cache is optional.

---
 rtl/inst_fetch_unit.sv | 206 ++++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//
// Purpose:
//   Responder side of the decoder's instruction-fetch port. A word-aligned
//   fetch request is turned into four byte reads through the memory arbiter.
//   The bytes are assembled little-endian into a 32-bit instruction, which is
//   returned with a one-cycle mc_rdy pulse.
//
// Optional feature:
//   ICACHE_EN - when defined, a direct-mapped instruction cache of
//   2^ICACHE_IDX_W one-word lines is added. A hit answers in one cycle with
//   no memory traffic. Reset invalidates the cache; flush does not.
//
// Ports:
//   clk_in   in   1   clock, rising edge
//   rst_in   in   1   asynchronous active-low reset
//   rdy_in   in   1   global enable, low freezes state
//   flush    in   1   mispredict flush (qualified by rdy_in)
//   mc_en    in   1   fetch request, held until mc_rdy
//   mc_addr  in  32   fetch address (word aligned)
//   mc_rdy   out  1   one-cycle pulse, mc_data valid
//   mc_data  out 32   fetched instruction (holds after the pulse)
//   mem_req  out  1   byte read request to the arbiter
//   mem_gnt  in   1   same-cycle grant; a byte issues on mem_req && mem_gnt
//   mem_a    out 32   byte address = base + issue count
//   mem_din  in   8   RAM read data, valid one cycle after the issue
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int ICACHE_IDX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        mc_en,
    input  logic [31:0] mc_addr,
    output logic        mc_rdy,
    output logic [31:0] mc_data,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_a,
    input  logic [7:0]  mem_din
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] base;
    logic [2:0]  issue_cnt;
    logic [2:0]  recv_cnt;
    logic        pend;
    logic [31:0] word;
    logic [31:0] word_cap;

    logic        issue_fire;
    logic        flush_go;
    logic        read_last;
    logic        accept;
    logic        mc_rdy_nxt;
    logic [31:0] mc_data_nxt;

    logic        cache_hit;
    logic [31:0] cache_word;

    assign issue_fire = mem_req && mem_gnt;
    assign flush_go   = flush && rdy_in;
    assign accept     = (state == S_IDLE) && mc_en && rdy_in && !flush;

    // Completion: either the last lane is landing on this edge, or it already
    // landed while rdy_in was low and the state had to wait.
    assign read_last  = (pend && (recv_cnt == 3'd3)) || (recv_cnt == 3'd4);

    // Current word with the in-flight byte merged into its lane.
    always_comb begin
        word_cap = word;
        if (pend) begin
            word_cap[{recv_cnt[1:0], 3'b000} +: 8] = mem_din;
        end
    end

`ifdef ICACHE_EN
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    logic [LINES-1:0]        c_valid;
    logic [TAG_W-1:0]        c_tag  [LINES];
    logic [31:0]             c_data [LINES];

    logic [ICACHE_IDX_W-1:0] req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [ICACHE_IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    cache_fill;

    assign req_idx    = mc_addr[ICACHE_IDX_W+1:2];
    assign req_tag    = mc_addr[31:ICACHE_IDX_W+2];
    assign fill_idx   = base[ICACHE_IDX_W+1:2];
    assign fill_tag   = base[31:ICACHE_IDX_W+2];
    assign cache_hit  = c_valid[req_idx] && (c_tag[req_idx] == req_tag);
    assign cache_word = c_data[req_idx];
    assign cache_fill = (state == S_READ) && (state_nxt == S_DONE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            c_valid <= '0;
        end else if (cache_fill) begin
            c_valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk_in) begin
        if (cache_fill) begin
            c_tag[fill_idx]  <= fill_tag;
            c_data[fill_idx] <= word_cap;
        end
    end
`else
    logic [ICACHE_IDX_W-1:0] unused_idx_w;

    assign unused_idx_w = '0;
    assign cache_hit    = 1'b0;
    assign cache_word   = '0;
`endif

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over everything, rdy_in low freezes.
    always_comb begin
        state_nxt = state;
        if (flush_go) begin
            state_nxt = S_IDLE;
        end else if (rdy_in) begin
            case (state)
                S_IDLE:  if (mc_en) state_nxt = cache_hit ? S_DONE : S_READ;
                S_READ:  if (read_last) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic: combinational memory side, next values of the
    // registered decoder-side outputs.
    always_comb begin
        mem_req     = (state == S_READ) && (issue_cnt < 3'd4) && rdy_in;
        mem_a       = base + {29'd0, issue_cnt};
        mc_rdy_nxt  = (state_nxt == S_DONE);
        mc_data_nxt = mc_data;
        if ((state_nxt == S_DONE) && (state != S_DONE)) begin
            mc_data_nxt = (state == S_IDLE) ? cache_word : word_cap;
        end
    end

    // Counters, byte assembly and registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pend      <= 1'b0;
            word      <= '0;
            mc_rdy    <= 1'b0;
            mc_data   <= '0;
        end else begin
            mc_rdy  <= mc_rdy_nxt;
            mc_data <= mc_data_nxt;
            if (flush_go) begin
                issue_cnt <= '0;
                recv_cnt  <= '0;
                pend      <= 1'b0;
            end else begin
                // A byte in flight is captured even while rdy_in is low.
                pend <= issue_fire;
                if (pend) begin
                    word     <= word_cap;
                    recv_cnt <= recv_cnt + 3'd1;
                end
                if (issue_fire) begin
                    issue_cnt <= issue_cnt + 3'd1;
                end
                if (accept) begin
                    base      <= mc_addr;
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                    word      <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam int NONE = 99;

    logic        clk_in  = 1'b0;
    logic        rst_in  = 1'b0;
    logic        rdy_in  = 1'b1;
    logic        flush   = 1'b0;
    logic        mc_en   = 1'b0;
    logic [31:0] mc_addr = '0;
    logic        mem_gnt = 1'b1;
    logic [7:0]  mem_din;
    logic        mc_rdy;
    logic [31:0] mc_data;
    logic        mem_req;
    logic [31:0] mem_a;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [31:0] issue_log [$];
    logic [31:0] stall_log [$];
    logic [31:0] sb_q      [$];
    int          frozen_req = 0;
    int          log_base;
    int          stall_base;
    int          frozen_base;

    always #5 clk_in = ~clk_in;

    inst_fetch_unit #(.ICACHE_IDX_W(6)) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .flush   (flush),
        .mc_en   (mc_en),
        .mc_addr (mc_addr),
        .mc_rdy  (mc_rdy),
        .mc_data (mc_data),
        .mem_req (mem_req),
        .mem_gnt (mem_gnt),
        .mem_a   (mem_a),
        .mem_din (mem_din)
    );

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {ram_rd(a + 32'd3), ram_rd(a + 32'd2), ram_rd(a + 32'd1), ram_rd(a)};
    endfunction

    // RAM behind the arbiter: one-cycle read latency, junk when idle.
    always @(posedge clk_in) begin
        if (mem_req && mem_gnt) begin
            issue_log.push_back(mem_a);
            mem_din <= ram_rd(mem_a);
        end else begin
            mem_din <= 8'($urandom);
        end
        if (mem_req && !mem_gnt) stall_log.push_back(mem_a);
        if (mem_req && !rdy_in) frozen_req <= frozen_req + 1;
    end

    task automatic apply_reset();
        @(negedge clk_in);
        rst_in  = 1'b0;
        mc_en   = 1'b0;
        flush   = 1'b0;
        rdy_in  = 1'b1;
        mem_gnt = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    // Drives one request from a negedge. gnt/rdy are low for edges in
    // [a,b]; flush_e >= 0 asserts flush for that edge. rdy_edge is the edge
    // index (request-sampling edge = 0) after which mc_rdy was seen, or -1.
    task automatic run_fetch(input logic [31:0] addr,
                             input int gnt_a, input int gnt_b,
                             input int rdy_a, input int rdy_b,
                             input int flush_e,
                             output int rdy_edge, output logic [31:0] data,
                             output logic pulse_ok);
        int e;
        rdy_edge    = -1;
        data        = '0;
        pulse_ok    = 1'b0;
        log_base    = issue_log.size();
        stall_base  = stall_log.size();
        frozen_base = frozen_req;
        mc_addr = addr;
        mc_en   = 1'b1;
        mem_gnt = !(0 >= gnt_a && 0 <= gnt_b);
        rdy_in  = !(0 >= rdy_a && 0 <= rdy_b);
        flush   = (flush_e == 0);
        e = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            e++;
            if (flush_e >= 0 && e == flush_e) begin
                flush = 1'b0;
                mc_en = 1'b0;
            end
            if (mc_rdy === 1'b1) begin
                rdy_edge = e;
                data     = mc_data;
                break;
            end
            if (flush_e >= 0 && e >= flush_e + 8) break;
            mem_gnt = !((e + 1) >= gnt_a && (e + 1) <= gnt_b);
            rdy_in  = !((e + 1) >= rdy_a && (e + 1) <= rdy_b);
            flush   = (flush_e >= 0 && (e + 1) == flush_e);
        end
        mem_gnt = 1'b1;
        rdy_in  = 1'b1;
        flush   = 1'b0;
        if (rdy_edge >= 0) begin
            // Decoder drops mc_en one edge late; DONE must ignore it.
            @(negedge clk_in);
            pulse_ok = (mc_rdy === 1'b0) && (mc_data === data);
        end
        mc_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        n_checks++; if (mc_rdy !== 1'b0) $display("FAIL reset_mc_rdy: got %b want 0", mc_rdy); else n_pass++;
        n_checks++; if (mc_data !== 32'h0) $display("FAIL reset_mc_data: got %h want 0", mc_data); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_a !== 32'h0) $display("FAIL reset_mem_a: got %h want 0", mem_a); else n_pass++;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL idle_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mc_rdy !== 1'b0) $display("FAIL idle_mc_rdy: got %b want 0", mc_rdy); else n_pass++;
    endtask

    task automatic test_basic();
        int re; logic [31:0] d, exp; logic pok;
        apply_reset();
        sb_q.push_back(exp_word(32'h1000));
        run_fetch(32'h1000, NONE, NONE, NONE, NONE, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (d !== exp) $display("FAIL basic_data: got %h want %h", d, exp); else n_pass++;
        n_checks++; if (d !== 32'h00000513) $display("FAIL basic_word: got %h want 00000513", d); else n_pass++;
        n_checks++; if (re !== 5) $display("FAIL basic_latency: got %0d want 5", re); else n_pass++;
        n_checks++; if (pok !== 1'b1) $display("FAIL basic_pulse: got %b want 1", pok); else n_pass++;
        n_checks++;
        if (issue_log.size() - log_base !== 4)
            $display("FAIL basic_issues: got %0d want 4", issue_log.size() - log_base);
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (issue_log[log_base + i] !== 32'h1000 + i)
                    $display("FAIL basic_addr%0d: got %h want %h", i, issue_log[log_base + i], 32'h1000 + i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_grant_loss();
        int re; logic [31:0] d, exp; logic pok;
        apply_reset();
        sb_q.push_back(exp_word(32'h1000));
        run_fetch(32'h1000, 3, 5, NONE, NONE, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (d !== exp) $display("FAIL gnt_data: got %h want %h", d, exp); else n_pass++;
        n_checks++; if (re !== 8) $display("FAIL gnt_latency: got %0d want 8", re); else n_pass++;
        n_checks++; if (issue_log.size() - log_base !== 4) $display("FAIL gnt_issues: got %0d want 4", issue_log.size() - log_base); else n_pass++;
        n_checks++;
        if (stall_log.size() - stall_base !== 3)
            $display("FAIL gnt_stalls: got %0d want 3", stall_log.size() - stall_base);
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (stall_log[stall_base + i] !== 32'h1002)
                    $display("FAIL gnt_hold_addr%0d: got %h want 00001002", i, stall_log[stall_base + i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rdy_stall();
        int re; logic [31:0] d, exp; logic pok;
        apply_reset();
        sb_q.push_back(exp_word(32'h1000));
        run_fetch(32'h1000, NONE, NONE, 3, 4, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (d !== exp) $display("FAIL rdy_data: got %h want %h", d, exp); else n_pass++;
        n_checks++; if (re !== 7) $display("FAIL rdy_latency: got %0d want 7", re); else n_pass++;
        n_checks++; if (issue_log.size() - log_base !== 4) $display("FAIL rdy_issues: got %0d want 4", issue_log.size() - log_base); else n_pass++;
        n_checks++; if (frozen_req - frozen_base !== 0) $display("FAIL rdy_req_frozen: got %0d want 0", frozen_req - frozen_base); else n_pass++;
    endtask

    task automatic test_flush();
        int re; logic [31:0] d, exp; logic pok;
        apply_reset();
        run_fetch(32'h1000, NONE, NONE, NONE, NONE, 4, re, d, pok);
        n_checks++; if (re !== -1) $display("FAIL flush_no_rdy: got edge %0d want none", re); else n_pass++;
        sb_q.push_back(exp_word(32'h2000));
        run_fetch(32'h2000, NONE, NONE, NONE, NONE, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (d !== exp) $display("FAIL flush_next_data: got %h want %h", d, exp); else n_pass++;
        n_checks++; if (d !== 32'h0000006F) $display("FAIL flush_next_word: got %h want 0000006f", d); else n_pass++;
        n_checks++; if (re !== 5) $display("FAIL flush_next_latency: got %0d want 5", re); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int re; logic [31:0] d, exp; logic pok;
        logic [31:0] addrs [3];
        addrs[0] = 32'h1000; addrs[1] = 32'h2000; addrs[2] = 32'h1100;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(exp_word(addrs[i]));
            run_fetch(addrs[i], NONE, NONE, NONE, NONE, -1, re, d, pok);
            exp = sb_q.pop_front();
            n_checks++; if (d !== exp) $display("FAIL b2b_data%0d: got %h want %h", i, d, exp); else n_pass++;
            n_checks++; if (pok !== 1'b1) $display("FAIL b2b_pulse%0d: got %b want 1", i, pok); else n_pass++;
            n_checks++; if (issue_log.size() - log_base !== 4) $display("FAIL b2b_issues%0d: got %0d want 4", i, issue_log.size() - log_base); else n_pass++;
        end
    endtask

    task automatic test_addr_boundary();
        int re; logic [31:0] d, exp; logic pok;
        apply_reset();
        sb_q.push_back(exp_word(32'hFFFF_FFFC));
        run_fetch(32'hFFFF_FFFC, NONE, NONE, NONE, NONE, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (d !== exp) $display("FAIL top_data: got %h want %h", d, exp); else n_pass++;
        n_checks++;
        if (issue_log.size() - log_base !== 4)
            $display("FAIL top_issues: got %0d want 4", issue_log.size() - log_base);
        else begin
            n_pass++;
            n_checks++;
            if (issue_log[log_base + 3] !== 32'hFFFF_FFFF)
                $display("FAIL top_last_addr: got %h want ffffffff", issue_log[log_base + 3]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midread();
        int re; logic [31:0] d, exp; logic pok;
        apply_reset();
        sb_q.push_back(exp_word(32'h0));
        run_fetch(32'h0, NONE, NONE, NONE, NONE, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (d !== exp) $display("FAIL pre_rst_data: got %h want %h", d, exp); else n_pass++;
        mc_addr = 32'h1000;
        mc_en   = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL midread_req: got %b want 1", mem_req); else n_pass++;
        #2 rst_in = 1'b0;
        #1;
        n_checks++; if (mc_rdy !== 1'b0) $display("FAIL async_rst_rdy: got %b want 0", mc_rdy); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL async_rst_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_a !== 32'h0) $display("FAIL async_rst_addr: got %h want 0", mem_a); else n_pass++;
        n_checks++; if (mc_data !== 32'h0) $display("FAIL async_rst_data: got %h want 0", mc_data); else n_pass++;
        mc_en = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        sb_q.push_back(exp_word(32'h0));
        run_fetch(32'h0, NONE, NONE, NONE, NONE, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (d !== exp) $display("FAIL post_rst_data: got %h want %h", d, exp); else n_pass++;
        n_checks++; if (re !== 5) $display("FAIL post_rst_latency: got %0d want 5", re); else n_pass++;
    endtask

`ifdef ICACHE_EN
    task automatic test_icache();
        int re; logic [31:0] d, exp; logic pok;
        apply_reset();
        sb_q.push_back(exp_word(32'h1000));
        run_fetch(32'h1000, NONE, NONE, NONE, NONE, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (re !== 5) $display("FAIL ic_miss_latency: got %0d want 5", re); else n_pass++;
        sb_q.push_back(exp_word(32'h1000));
        run_fetch(32'h1000, NONE, NONE, NONE, NONE, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (d !== exp) $display("FAIL ic_hit_data: got %h want %h", d, exp); else n_pass++;
        n_checks++; if (re !== 0) $display("FAIL ic_hit_latency: got %0d want 0", re); else n_pass++;
        n_checks++; if (issue_log.size() - log_base !== 0) $display("FAIL ic_hit_issues: got %0d want 0", issue_log.size() - log_base); else n_pass++;
        sb_q.push_back(exp_word(32'h1100));
        run_fetch(32'h1100, NONE, NONE, NONE, NONE, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (d !== exp) $display("FAIL ic_conflict_data: got %h want %h", d, exp); else n_pass++;
        n_checks++; if (re !== 5) $display("FAIL ic_conflict_latency: got %0d want 5", re); else n_pass++;
        // Flush leaves the cache intact.
        @(negedge clk_in); flush = 1'b1;
        @(negedge clk_in); flush = 1'b0;
        sb_q.push_back(exp_word(32'h1100));
        run_fetch(32'h1100, NONE, NONE, NONE, NONE, -1, re, d, pok);
        exp = sb_q.pop_front();
        n_checks++; if (d !== exp) $display("FAIL ic_post_flush_data: got %h want %h", d, exp); else n_pass++;
        n_checks++; if (re !== 0) $display("FAIL ic_post_flush_latency: got %0d want 0", re); else n_pass++;
    endtask
`endif

    initial begin
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        ram[32'h2000] = 8'h6F; ram[32'h2001] = 8'h00; ram[32'h2002] = 8'h00; ram[32'h2003] = 8'h00;
        ram[32'h1100] = 8'hB7; ram[32'h1101] = 8'h12; ram[32'h1102] = 8'h34; ram[32'h1103] = 8'h00;
        ram[32'h0000] = 8'h93; ram[32'h0001] = 8'h00; ram[32'h0002] = 8'h10; ram[32'h0003] = 8'h00;
        test_reset();
        test_basic();
        test_grant_loss();
        test_rdy_stall();
        test_flush();
        test_back_to_back();
        test_addr_boundary();
        test_reset_midread();
`ifdef ICACHE_EN
        test_icache();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
